// File: rtl/axrm_pkg.sv
// Shared widths and FSM encoding for the AxRM characterisation stages.
package axrm_pkg;

  // Product width for a WIDTH x WIDTH multiplier.
  function automatic int unsigned prod_w(input int unsigned width);
    return 2 * width;
  endfunction

  // Count width: holds up to 2^(2*WIDTH) samples.
  function automatic int unsigned count_w(input int unsigned width);
    return 2 * width + 1;
  endfunction

  // Error-distance sum width: holds (2^P - 1) * 2^P.
  function automatic int unsigned sum_w(input int unsigned width);
    return 4 * width;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/axrm_error_accum_if.sv
// Sample stream from the multiplier under test: operands, approximate product, handshake.
interface axrm_error_accum_if
  import axrm_pkg::*;
#(
  parameter int unsigned WIDTH = 8
);

  localparam int unsigned P = prod_w(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [P-1:0]     in_y;

  modport master (output in_valid, output in_a, output in_b, output in_y, input in_ready);
  modport slave  (input in_valid, input in_a, input in_b, input in_y, output in_ready);

endinterface

// File: rtl/axrm_abs_diff.sv
// Combinational unsigned |x - y| without wrap.
module axrm_abs_diff #(
  parameter int unsigned P = 16
) (
  input  logic [P-1:0] x,
  input  logic [P-1:0] y,
  output logic [P-1:0] diff_c
);

  // Subtract the smaller operand from the larger one.
  always_comb begin
    diff_c = '0;
    if (x >= y) diff_c = x - y;
    else        diff_c = y - x;
  end

endmodule

// File: rtl/axrm_error_accum.sv
// Error-statistics accumulator for approximate multipliers: exact product,
// error distance, and run-level count/sum/max over a programmable sample run.
module axrm_error_accum
  import axrm_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned P     = prod_w(WIDTH),
  localparam int unsigned C     = count_w(WIDTH),
  localparam int unsigned S     = sum_w(WIDTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [C-1:0]             num_samples,
  axrm_error_accum_if.slave        smp,
  output logic                     busy,
  output logic                     done,
  output logic [C-1:0]             sample_count,
  output logic [C-1:0]             err_count,
  output logic [S-1:0]             ed_sum,
  output logic [P-1:0]             ed_max
);

  state_t       state;
  logic [C-1:0] num_latched;
  logic [C-1:0] accepted;
  logic         ready_q;

  logic         s1_valid;
  logic [P-1:0] s1_exact;
  logic [P-1:0] s1_y;
  logic         s2_valid;
  logic [P-1:0] s2_ed;

  logic         take_c;
  logic         last_c;
  logic [P-1:0] ed_c;

  assign smp.in_ready = ready_q;
  assign take_c       = smp.in_valid && ready_q;
  // accepted < num_latched whenever ready is high, so the increment cannot wrap.
  assign last_c       = ((accepted + C'(1)) == num_latched);

  axrm_abs_diff #(.P(P)) u_abs_diff (
    .x      (s1_exact),
    .y      (s1_y),
    .diff_c (ed_c)
  );

  // Run control: state, accept counter and registered handshake/status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      num_latched <= '0;
      accepted    <= '0;
      ready_q     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else if (start) begin
      num_latched <= num_samples;
      accepted    <= '0;
      if (num_samples == '0) begin
        state   <= ST_DONE;
        ready_q <= 1'b0;
        busy    <= 1'b0;
        done    <= 1'b1;
      end else begin
        state   <= ST_RUN;
        ready_q <= 1'b1;
        busy    <= 1'b1;
        done    <= 1'b0;
      end
    end else begin
      case (state)
        ST_RUN: begin
          if (take_c) begin
            accepted <= accepted + C'(1);
            if (last_c) begin
              state   <= ST_DRAIN;
              ready_q <= 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          if (!s1_valid && !s2_valid) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        ST_IDLE, ST_DONE: begin
          state <= state;
        end
        default: begin
          state   <= ST_IDLE;
          ready_q <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

  // Two-stage datapath: exact product capture, then registered error distance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_exact <= '0;
      s1_y     <= '0;
      s2_valid <= 1'b0;
      s2_ed    <= '0;
    end else if (start) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      s1_valid <= take_c;
      if (take_c) begin
        s1_exact <= P'(smp.in_a) * P'(smp.in_b);
        s1_y     <= smp.in_y;
      end
      s2_valid <= s1_valid;
      if (s1_valid) s2_ed <= ed_c;
    end
  end

  // Statistics accumulation; widths are sized so nothing saturates or wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_count <= '0;
      err_count    <= '0;
      ed_sum       <= '0;
      ed_max       <= '0;
    end else if (start) begin
      sample_count <= '0;
      err_count    <= '0;
      ed_sum       <= '0;
      ed_max       <= '0;
    end else if (s2_valid) begin
      sample_count <= sample_count + C'(1);
      err_count    <= err_count + C'(s2_ed != '0);
      ed_sum       <= ed_sum + S'(s2_ed);
      if (s2_ed > ed_max) ed_max <= s2_ed;
    end
  end

endmodule

// File: tb/tb_axrm_error_accum.sv
// Directed bench for axrm_error_accum, including an exhaustive AxRM1 sweep.
module tb_axrm_error_accum;
  import axrm_pkg::*;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned P     = prod_w(WIDTH);
  localparam int unsigned C     = count_w(WIDTH);
  localparam int unsigned S     = sum_w(WIDTH);

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [C-1:0] num_samples;
  logic         busy;
  logic         done;
  logic [C-1:0] sample_count;
  logic [C-1:0] err_count;
  logic [S-1:0] ed_sum;
  logic [P-1:0] ed_max;

  int n_cmp = 0;
  int n_err = 0;

  axrm_error_accum_if #(.WIDTH(WIDTH)) smp ();

  axrm_error_accum #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .num_samples  (num_samples),
    .smp          (smp),
    .busy         (busy),
    .done         (done),
    .sample_count (sample_count),
    .err_count    (err_count),
    .ed_sum       (ed_sum),
    .ed_max       (ed_max)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_stats(input string tag, input int sc, input int ec,
                             input longint es, input int em);
    check({tag, ".sample_count"}, 64'(sample_count), 64'(sc));
    check({tag, ".err_count"},    64'(err_count),    64'(ec));
    check({tag, ".ed_sum"},       64'(ed_sum),       64'(es));
    check({tag, ".ed_max"},       64'(ed_max),       64'(em));
  endtask

  task automatic drive(input logic v, input int a, input int b, input int y);
    smp.in_valid = v;
    smp.in_a     = WIDTH'(a);
    smp.in_b     = WIDTH'(b);
    smp.in_y     = P'(y);
  endtask

  // AxRM1 reference: 2x2 block returns 7 for 3x3, composed recursively.
  function automatic int m2(input int a, input int b);
    if (a == 3 && b == 3) return 7;
    return a * b;
  endfunction

  function automatic int m4(input int a, input int b);
    int ah, al, bh, bl;
    ah = (a >> 2) & 3; al = a & 3;
    bh = (b >> 2) & 3; bl = b & 3;
    return (m2(ah, bh) << 4) + ((m2(ah, bl) + m2(al, bh)) << 2) + m2(al, bl);
  endfunction

  function automatic int m8(input int a, input int b);
    int ah, al, bh, bl;
    ah = (a >> 4) & 15; al = a & 15;
    bh = (b >> 4) & 15; bl = b & 15;
    return ((m4(ah, bh) << 8) + ((m4(ah, bl) + m4(al, bh)) << 4) + m4(al, bl)) & 16'hffff;
  endfunction

  initial begin
    int     sw_err;
    longint sw_sum;
    int     sw_max;
    int     ex;
    int     ap;
    int     d;

    rst = 1'b1;
    start = 1'b0;
    num_samples = '0;
    drive(1'b0, 0, 0, 0);
    step();
    step();
    // Reset state
    check("rst.busy", 64'(busy), 0);
    check("rst.done", 64'(done), 0);
    check("rst.in_ready", 64'(smp.in_ready), 0);
    check_stats("rst", 0, 0, 0, 0);
    rst = 1'b0;
    step();

    // Exact products, num = 4
    start = 1'b1; num_samples = C'(4);
    step();
    start = 1'b0;
    check("t1.busy", 64'(busy), 1);
    check("t1.in_ready", 64'(smp.in_ready), 1);
    drive(1'b1, 3, 5, 15);      step();
    drive(1'b1, 255, 255, 65025); step();
    drive(1'b1, 0, 7, 0);       step();
    drive(1'b1, 16, 16, 256);   step();
    drive(1'b0, 0, 0, 0);
    check("t1.ready_low", 64'(smp.in_ready), 0);
    step();
    step();
    check("t1.done_t2", 64'(done), 0);
    check("t1.busy_t2", 64'(busy), 1);
    step();
    check("t1.done_t3", 64'(done), 1);
    check("t1.busy_t3", 64'(busy), 0);
    check_stats("t1", 4, 0, 0, 0);

    // Mixed errors, num = 3, with latency observation
    start = 1'b1; num_samples = C'(3);
    step();
    start = 1'b0;
    check_stats("t2.clr", 0, 0, 0, 0);
    drive(1'b1, 3, 3, 5);     step();
    check("t2.lat1", 64'(sample_count), 0);
    drive(1'b1, 255, 255, 0); step();
    check("t2.lat2", 64'(sample_count), 0);
    drive(1'b1, 2, 2, 4);     step();
    check("t2.lat3", 64'(sample_count), 1);
    check("t2.lat3_sum", 64'(ed_sum), 4);
    drive(1'b0, 0, 0, 0);
    step();
    step();
    step();
    check("t2.done", 64'(done), 1);
    check_stats("t2", 3, 2, 65029, 65025);

    // Zero-length run
    start = 1'b1; num_samples = C'(0);
    step();
    start = 1'b0;
    check("t3.done", 64'(done), 1);
    check("t3.busy", 64'(busy), 0);
    check("t3.in_ready", 64'(smp.in_ready), 0);
    check_stats("t3", 0, 0, 0, 0);
    step();
    check("t3.busy_later", 64'(busy), 0);

    // num = 2, valid pattern 1,0,1,1,1
    start = 1'b1; num_samples = C'(2);
    step();
    start = 1'b0;
    drive(1'b1, 1, 1, 1);     step();
    drive(1'b0, 0, 0, 0);     step();
    drive(1'b1, 2, 3, 7);     step();
    check("t4.ready_low", 64'(smp.in_ready), 0);
    drive(1'b1, 200, 200, 0); step();
    drive(1'b1, 200, 200, 0); step();
    drive(1'b0, 0, 0, 0);
    step();
    check("t4.done", 64'(done), 1);
    check_stats("t4", 2, 1, 1, 1);

    // start mid-run with two samples in flight
    start = 1'b1; num_samples = C'(5);
    step();
    start = 1'b0;
    drive(1'b1, 255, 255, 0); step();
    drive(1'b1, 255, 255, 1); step();
    drive(1'b0, 0, 0, 0);
    start = 1'b1; num_samples = C'(1);
    step();
    start = 1'b0;
    check("t5.busy", 64'(busy), 1);
    check("t5.in_ready", 64'(smp.in_ready), 1);
    check_stats("t5.clr", 0, 0, 0, 0);
    drive(1'b1, 1, 1, 0); step();
    drive(1'b0, 0, 0, 0);
    step();
    step();
    step();
    check("t5.done", 64'(done), 1);
    check_stats("t5", 1, 1, 1, 1);

    // Asynchronous reset mid-run
    start = 1'b1; num_samples = C'(10);
    step();
    start = 1'b0;
    drive(1'b1, 255, 255, 0); step();
    step();
    step();
    check("t6.pre", 64'(sample_count), 1);
    #2 rst = 1'b1;
    #1;
    check("t6.busy", 64'(busy), 0);
    check("t6.done", 64'(done), 0);
    check("t6.in_ready", 64'(smp.in_ready), 0);
    check_stats("t6", 0, 0, 0, 0);
    drive(1'b0, 0, 0, 0);
    step();
    rst = 1'b0;
    step();
    step();
    check("t6.idle_busy", 64'(busy), 0);
    check("t6.idle_count", 64'(sample_count), 0);

    // Exhaustive AxRM1 sweep
    sw_err = 0; sw_sum = 0; sw_max = 0;
    start = 1'b1; num_samples = C'(65536);
    step();
    start = 1'b0;
    for (int i = 0; i < 65536; i++) begin
      ex = (i >> 8) * (i & 255);
      ap = m8(i >> 8, i & 255);
      d  = (ex >= ap) ? ex - ap : ap - ex;
      if (d != 0) sw_err++;
      sw_sum += longint'(d);
      if (d > sw_max) sw_max = d;
      drive(1'b1, i >> 8, i & 255, ap);
      step();
    end
    drive(1'b0, 0, 0, 0);
    check("t7.ready_low", 64'(smp.in_ready), 0);
    step();
    step();
    step();
    check("t7.done", 64'(done), 1);
    check_stats("t7", 65536, sw_err, sw_sum, sw_max);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
